// File: rtl/pool_result_streamer_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pool_result_streamer_pkg: shared layer-2 sizing constants and the FSM  |
// | state encoding.                                   Revision 1.0         |
// +-----------------------------------------------------------------------+
package pool_result_streamer_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 169;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  // True when index idx is the final beat of a map holding cnt bytes.
  function automatic logic beat_is_last(input int idx, input int cnt);
    return (idx == cnt - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pool_result_streamer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pool_result_streamer_if: valid/ready byte stream with end-of-map flag. |
// |                                                   Revision 1.0         |
// +-----------------------------------------------------------------------+
interface pool_result_streamer_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );

endinterface

`default_nettype wire

// File: rtl/pool_result_streamer_ram.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pool_buf_ram: simple dual-port buffer, one write port and a registered |
// | read port with one cycle of latency.              Revision 1.0         |
// +-----------------------------------------------------------------------+
module pool_buf_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 169,
  parameter int ADDR_W = 8
) (
  input  wire logic              clk,
  input  wire logic              we,
  input  wire logic [ADDR_W-1:0] waddr,
  input  wire logic [DATA_W-1:0] wdata,
  input  wire logic              re,
  input  wire logic [ADDR_W-1:0] raddr,
  output logic      [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/pool_result_streamer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pool_result_streamer: buffers one pooled layer-2 feature map, then     |
// | drains it over a valid/ready byte stream.         Revision 1.0         |
// +-----------------------------------------------------------------------+
module pool_result_streamer
  import pool_result_streamer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic [DATA_W-1:0] d_in,
  input  wire logic              data_available,
  input  wire logic              layer_2_ready,
  pool_result_streamer_if.master m,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] count;

  // Read pipeline: a read issued in cycle t presents ram_rdata in cycle t+1.
  logic              rd_pend;
  logic              rd_pend_last;
  logic [DATA_W-1:0] ram_rdata;

  // Skid register catches the in-flight read when the output stalls.
  logic              sk_valid;
  logic              sk_last;
  logic [DATA_W-1:0] sk_data;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_next;
  logic              fill_exit;
  logic              pop;
  logic              last_xfer;
  logic [1:0]        occ;
  logic              issue;

  always_comb begin
    wr_en     = (state == FILL) && data_available && (wr_ptr != DEPTH_A);
    wr_next   = wr_en ? (wr_ptr + ONE_A) : wr_ptr;
    fill_exit = (state == FILL) && (layer_2_ready || (wr_next == DEPTH_A));
    pop       = m.m_valid && m.m_ready;
    last_xfer = pop && m.m_last;
    // Beats held or in flight after this cycle's pop; two slots exist (output + skid).
    occ       = {1'b0, m.m_valid} + {1'b0, sk_valid} + {1'b0, rd_pend} - {1'b0, pop};
    issue     = (state == DRAIN) && (rd_ptr != count) && (occ < 2'd2);
  end

  pool_buf_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (d_in),
    .re    (issue),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FILL;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
      sk_valid     <= 1'b0;
      sk_last      <= 1'b0;
      sk_data      <= '0;
      m.m_valid    <= 1'b0;
      m.m_last     <= 1'b0;
      m.m_data     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      // Any byte that cannot be stored is lost and flagged until reset.
      if (data_available && !wr_en) begin
        overflow <= 1'b1;
      end

      done <= 1'b0;
      case (state)
        FILL: begin
          if (wr_en) begin
            wr_ptr <= wr_next;
          end
          if (fill_exit) begin
            count <= wr_next;
            if (wr_next == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= DRAIN;
              busy  <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (issue) begin
            rd_ptr <= rd_ptr + ONE_A;
          end
          if (last_xfer) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state  <= FILL;
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
        end
        default: begin
          state <= FILL;
          busy  <= 1'b0;
        end
      endcase

      rd_pend      <= issue;
      rd_pend_last <= issue && beat_is_last(int'(rd_ptr), int'(count));

      if (!m.m_valid || m.m_ready) begin
        if (sk_valid) begin
          m.m_valid <= 1'b1;
          m.m_data  <= sk_data;
          m.m_last  <= sk_last;
          sk_valid  <= rd_pend;
          sk_data   <= ram_rdata;
          sk_last   <= rd_pend_last;
        end else if (rd_pend) begin
          m.m_valid <= 1'b1;
          m.m_data  <= ram_rdata;
          m.m_last  <= rd_pend_last;
        end else begin
          m.m_valid <= 1'b0;
          m.m_last  <= 1'b0;
        end
      end else if (rd_pend) begin
        sk_valid <= 1'b1;
        sk_data  <= ram_rdata;
        sk_last  <= rd_pend_last;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pool_result_streamer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_pool_result_streamer: queue-model bench for the pooled-map streamer.|
// |                                                   Revision 1.0         |
// +-----------------------------------------------------------------------+
module tb_pool_result_streamer;

  localparam int DEPTH = 169;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d_in = 8'h00;
  logic       data_available = 1'b0;
  logic       layer_2_ready = 1'b0;
  logic       busy, done, overflow;

  pool_result_streamer_if #(.DATA_W(8)) sif ();

  pool_result_streamer #(.DATA_W(8), .DEPTH(DEPTH), .ADDR_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .d_in           (d_in),
    .data_available (data_available),
    .layer_2_ready  (layer_2_ready),
    .m              (sif),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: bytes the map must deliver, in order, plus expected flags.
  logic [7:0] exp_q[$];
  logic [7:0] fd [0:255];
  bit   ovf_m = 1'b0;
  bit   done_exp = 1'b0;
  bit   drop_now = 1'b0;
  bit   empty_now = 1'b0;
  bit   after_rst = 1'b0;
  bit   hold_v = 1'b0;
  logic [7:0] hold_d;
  logic hold_l;
  int   beats = 0;
  int   done_cnt = 0;
  int   stall_a3 = 0;
  logic [7:0] last_beat_d = 8'h00;

  int   ready_mode = 0;
  int   stall_val = -1;
  int   stall_cnt = 0;
  bit   release_next = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Consumer ready generator, applied after the driver has updated its controls.
  initial begin
    sif.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (stall_cnt > 0) begin
        sif.m_ready = 1'b0;
        stall_cnt--;
        if (stall_cnt == 0) release_next = 1'b1;
      end else if (stall_val >= 0 && sif.m_valid && sif.m_data == stall_val[7:0]) begin
        sif.m_ready = 1'b0;
        stall_cnt   = 4;
        stall_val   = -1;
      end else if (release_next) begin
        sif.m_ready  = 1'b1;
        release_next = 1'b0;
      end else begin
        case (ready_mode)
          0: sif.m_ready = 1'b1;
          1: sif.m_ready = ~sif.m_ready;
          2: sif.m_ready = ($urandom_range(0, 3) != 0);
          default: sif.m_ready = 1'b0;
        endcase
      end
    end
  end

  // Per-cycle compare against the queue model.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      ovf_m     = 1'b0;
      done_exp  = 1'b0;
      hold_v    = 1'b0;
      after_rst = 1'b1;
    end else begin
      if (after_rst) begin
        chk("rst_m_valid", {31'd0, sif.m_valid}, 32'd0);
        chk("rst_m_last", {31'd0, sif.m_last}, 32'd0);
        chk("rst_m_data", {24'd0, sif.m_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        after_rst = 1'b0;
      end
      chk("overflow", {31'd0, overflow}, {31'd0, ovf_m});
      chk("done", {31'd0, done}, {31'd0, done_exp});
      if (done) begin
        done_cnt++;
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_valid", {31'd0, sif.m_valid}, 32'd0);
      end
      if (sif.m_valid) chk("valid_busy", {31'd0, busy}, 32'd1);
      if (hold_v) begin
        chk("hold_valid", {31'd0, sif.m_valid}, 32'd1);
        chk("hold_data", {24'd0, sif.m_data}, {24'd0, hold_d});
        chk("hold_last", {31'd0, sif.m_last}, {31'd0, hold_l});
      end
      if (sif.m_valid && !sif.m_ready && sif.m_data == 8'hA3) stall_a3++;
      done_exp = 1'b0;
      if (sif.m_valid && sif.m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {24'd0, sif.m_data}, 32'hFFFF_FFFF);
        end else begin
          chk("beat_data", {24'd0, sif.m_data}, {24'd0, exp_q[0]});
          chk("beat_last", {31'd0, sif.m_last}, (exp_q.size() == 1) ? 32'd1 : 32'd0);
          if (exp_q.size() == 1) done_exp = 1'b1;
          if (sif.m_last) last_beat_d = sif.m_data;
          void'(exp_q.pop_front());
          beats++;
        end
      end
      hold_v = sif.m_valid && !sif.m_ready;
      hold_d = sif.m_data;
      hold_l = sif.m_last;
      if (data_available && drop_now) ovf_m = 1'b1;
      if (layer_2_ready && empty_now) done_exp = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    data_available = 1'b0;
    layer_2_ready  = 1'b0;
    drop_now       = 1'b0;
    empty_now      = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit l2r_last, input int gap_max);
    int g;
    for (int i = 0; i < n; i++) begin
      g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      for (int j = 0; j < g; j++) tick();
      d_in = fd[i];
      data_available = 1'b1;
      if (i < DEPTH) exp_q.push_back(fd[i]);
      else drop_now = 1'b1;
      if (l2r_last && i == n - 1 && i < DEPTH) layer_2_ready = 1'b1;
      tick();
    end
    if (!(l2r_last && n > 0) && n < DEPTH) begin
      layer_2_ready = 1'b1;
      empty_now = (n == 0);
      tick();
    end
  endtask

  task automatic measure_latency();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!sif.m_valid && k < 20);
    chk("first_valid_latency", k, 3);
  endtask

  task automatic wait_done(input bit inject);
    int k = 0;
    bit seen = 1'b0;
    while (!seen && k < 3000) begin
      if (inject && busy && $urandom_range(0, 4) == 0) begin
        data_available = 1'b1;
        d_in = 8'($urandom);
        drop_now = 1'b1;
      end
      @(negedge clk);
      if (done) seen = 1'b1;
      tick();
      k++;
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic frame_end(input string nm, input int n);
    tick();
    tick();
    chk({nm, "_beats"}, beats, n);
    chk({nm, "_done_pulses"}, done_cnt, 1);
    chk({nm, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int k;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    ready_mode = 0;
    tick();

    // Full frame, ready held high.
    for (int i = 0; i < DEPTH; i++) fd[i] = 8'(i);
    beats = 0; done_cnt = 0;
    send_frame(DEPTH, 1'b0, 0);
    measure_latency();
    wait_done(1'b0);
    frame_end("full", DEPTH);
    chk("full_last_data", {24'd0, last_beat_d}, 32'd168);
    chk("full_overflow", {31'd0, overflow}, 32'd0);

    // Backpressure: toggling ready with a 5-cycle stall on 0xA3.
    for (int i = 0; i < 10; i++) fd[i] = 8'(8'hA0 + i);
    beats = 0; done_cnt = 0; stall_a3 = 0;
    ready_mode = 1; stall_val = 8'hA3;
    send_frame(10, 1'b0, 0);
    measure_latency();
    wait_done(1'b0);
    frame_end("bp", 10);
    chk("bp_stall_cycles", stall_a3, 5);
    chk("bp_last_data", {24'd0, last_beat_d}, 32'hA9);

    // Write coinciding with layer_2_ready.
    ready_mode = 2;
    fd[0] = 8'h11; fd[1] = 8'h22; fd[2] = 8'h33; fd[3] = 8'h44; fd[4] = 8'h55;
    beats = 0; done_cnt = 0;
    send_frame(5, 1'b1, 0);
    wait_done(1'b0);
    frame_end("simul", 5);
    chk("simul_last_data", {24'd0, last_beat_d}, 32'h55);

    // Empty frame.
    beats = 0; done_cnt = 0;
    send_frame(0, 1'b0, 0);
    chk("empty_busy", {31'd0, busy}, 32'd0);
    wait_done(1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("empty_busy_after", {31'd0, busy}, 32'd0);
      chk("empty_valid_after", {31'd0, sif.m_valid}, 32'd0);
      tick();
    end
    frame_end("empty", 0);

    // Randomized frames.
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) fd[i] = 8'($urandom);
      beats = 0; done_cnt = 0;
      send_frame(n, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      wait_done(1'b0);
      frame_end("rand", n);
    end
    for (int i = 0; i < DEPTH; i++) fd[i] = 8'($urandom);
    beats = 0; done_cnt = 0;
    send_frame(DEPTH, 1'b0, 1);
    wait_done(1'b0);
    frame_end("rand_full", DEPTH);

    // Overflow: 170 bytes plus stray bytes during DRAIN.
    ready_mode = 0;
    for (int i = 0; i < 170; i++) fd[i] = 8'($urandom);
    beats = 0; done_cnt = 0;
    send_frame(170, 1'b0, 0);
    wait_done(1'b1);
    frame_end("ovf", DEPTH);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset while beat 50 is stalled.
    for (int i = 0; i < DEPTH; i++) fd[i] = 8'(i);
    beats = 0; done_cnt = 0;
    send_frame(DEPTH, 1'b0, 0);
    k = 0;
    while (!(sif.m_valid && sif.m_data == 8'd50) && k < 400) begin
      tick();
      k++;
    end
    chk("rst_reach_beat50", (k < 400) ? 32'd1 : 32'd0, 32'd1);
    ready_mode = 3;
    tick(); tick(); tick();
    chk("beats_before_rst", beats, 50);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", {31'd0, sif.m_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_overflow", {31'd0, overflow}, 32'd0);
    tick();
    ready_mode = 0;
    fd[0] = 8'h5A; fd[1] = 8'hC3; fd[2] = 8'h0F;
    beats = 0; done_cnt = 0;
    send_frame(3, 1'b0, 0);
    wait_done(1'b0);
    frame_end("post_rst", 3);
    chk("post_rst_last", {24'd0, last_beat_d}, 32'h0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
